// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and data (D) requesters.
// Grants are held until mem_ack or timeout; responses are registered one-cycle pulses.
//   state | meaning
//   IDLE  | no owner, choose next grant
//   ISSUE | mem_req held with latched command, waiting for ack or timeout
//   RESP  | owner's ready (and err) pulse, then release
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic             err,
  output logic [1:0]       grant,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [3:0]       r_mem_be;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] r_i_rdata;
  logic [WIDTH-1:0] r_d_rdata;
  logic             r_i_ready;
  logic             r_d_ready;
  logic             r_err;
  logic [3:0]       r_starve_cnt;
  logic [TW-1:0]    r_tmo_cnt;

  logic             w_grant_i;
  logic             w_tmo_hit;
  logic [WIDTH-1:0] w_resp_data;

  // D wins ties unless I has been passed over STARVE_LIMIT times in a row
  assign w_grant_i   = i_req && (!d_req || (r_starve_cnt == 4'(STARVE_LIMIT)));
  assign w_tmo_hit   = (TIMEOUT != 0) && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_resp_data = (mem_ack && !r_mem_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_err        <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_tmo_cnt    <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_req) r_starve_cnt <= 4'd0;
          if (w_grant_i) begin
            r_grant      <= 2'b01;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b1111;
            r_mem_addr   <= i_addr;
            r_mem_wdata  <= '0;
            r_starve_cnt <= 4'd0;
            r_mem_req    <= 1'b1;
            r_tmo_cnt    <= '0;
            r_state      <= ISSUE;
          end else if (d_req) begin
            r_grant     <= 2'b10;
            r_mem_we    <= d_we;
            r_mem_be    <= d_we ? d_be : 4'b1111;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (i_req && (r_starve_cnt != 4'(STARVE_LIMIT)))
              r_starve_cnt <= r_starve_cnt + 4'd1;
            r_mem_req   <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack || w_tmo_hit) begin
            r_mem_req <= 1'b0;
            r_err     <= !mem_ack;
            if (r_grant[0]) begin
              r_i_ready <= 1'b1;
              r_i_rdata <= w_resp_data;
            end else begin
              r_d_ready <= 1'b1;
              r_d_rdata <= w_resp_data;
            end
            r_state <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          r_grant   <= 2'b00;
          r_i_rdata <= '0;
          r_d_rdata <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign err       = r_err;
  assign grant     = r_grant;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand sequences for tie-break, starvation, timeout, stability and reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic [1:0]  grant;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_delay;
  int wait_cnt;
  logic [31:0] rd_val;

  mem_port_arbiter #(.WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err), .grant(grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_val;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // one clock: advance to the falling edge, then update the memory model
  task automatic tick();
    @(negedge clk);
    if (mem_req) begin
      if (ack_delay >= 0 && wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
      end else begin
        mem_ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  endtask

  initial begin
    int n;
    logic [1:0] starve_exp [6];

    vecs[0] = '{i_req:1, d_req:0, d_we:0, d_be:4'h0, i_addr:32'h0000_0010, d_addr:32'h0,
                d_wdata:32'h0, mem_val:32'h0050_0513, exp_grant:2'b01, exp_we:0, exp_be:4'hF,
                exp_addr:32'h0000_0010, exp_wdata:32'h0, exp_rdata:32'h0050_0513};
    vecs[1] = '{i_req:0, d_req:1, d_we:0, d_be:4'h3, i_addr:32'h0, d_addr:32'h0000_0200,
                d_wdata:32'h1111_1111, mem_val:32'h1234_5678, exp_grant:2'b10, exp_we:0, exp_be:4'hF,
                exp_addr:32'h0000_0200, exp_wdata:32'h1111_1111, exp_rdata:32'h1234_5678};
    vecs[2] = '{i_req:1, d_req:1, d_we:1, d_be:4'h3, i_addr:32'h0000_0040, d_addr:32'h0000_0100,
                d_wdata:32'hDEAD_BEEF, mem_val:32'hCAFE_F00D, exp_grant:2'b10, exp_we:1, exp_be:4'h3,
                exp_addr:32'h0000_0100, exp_wdata:32'hDEAD_BEEF, exp_rdata:32'h0};
    vecs[3] = '{i_req:0, d_req:1, d_we:1, d_be:4'hC, i_addr:32'h0, d_addr:32'h0000_0104,
                d_wdata:32'h0BAD_F00D, mem_val:32'h5555_AAAA, exp_grant:2'b10, exp_we:1, exp_be:4'hC,
                exp_addr:32'h0000_0104, exp_wdata:32'h0BAD_F00D, exp_rdata:32'h0};
    vecs[4] = '{i_req:1, d_req:0, d_we:1, d_be:4'h1, i_addr:32'hFFFF_FFFC, d_addr:32'h0,
                d_wdata:32'h0, mem_val:32'hFFFF_FFFF, exp_grant:2'b01, exp_we:0, exp_be:4'hF,
                exp_addr:32'hFFFF_FFFC, exp_wdata:32'h0, exp_rdata:32'hFFFF_FFFF};

    starve_exp[0] = 2'b10; starve_exp[1] = 2'b10; starve_exp[2] = 2'b10;
    starve_exp[3] = 2'b10; starve_exp[4] = 2'b01; starve_exp[5] = 2'b10;

    rst = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 0;
    ack_delay = 0; wait_cnt = 0; rd_val = '0;

    tick(); tick();
    chk("reset grant", {30'd0, grant}, 32'd0);
    chk("reset ready/err/mem_req", {28'd0, i_ready, d_ready, err, mem_req}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_be/we", {27'd0, mem_be, mem_we}, 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[v]) begin
      i_req = vecs[v].i_req; d_req = vecs[v].d_req; d_we = vecs[v].d_we;
      d_be = vecs[v].d_be; i_addr = vecs[v].i_addr; d_addr = vecs[v].d_addr;
      d_wdata = vecs[v].d_wdata; rd_val = vecs[v].mem_val; ack_delay = 0;
      tick();
      chk($sformatf("v%0d mem_req", v), {31'd0, mem_req}, 32'd1);
      chk($sformatf("v%0d grant", v), {30'd0, grant}, {30'd0, vecs[v].exp_grant});
      chk($sformatf("v%0d mem_we", v), {31'd0, mem_we}, {31'd0, vecs[v].exp_we});
      chk($sformatf("v%0d mem_be", v), {28'd0, mem_be}, {28'd0, vecs[v].exp_be});
      chk($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].exp_addr);
      chk($sformatf("v%0d mem_wdata", v), mem_wdata, vecs[v].exp_wdata);
      tick();
      chk($sformatf("v%0d i_ready", v), {31'd0, i_ready}, {31'd0, vecs[v].exp_grant[0]});
      chk($sformatf("v%0d d_ready", v), {31'd0, d_ready}, {31'd0, vecs[v].exp_grant[1]});
      chk($sformatf("v%0d rdata", v), vecs[v].exp_grant[0] ? i_rdata : d_rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d err", v), {31'd0, err}, 32'd0);
      chk($sformatf("v%0d mem_req dropped", v), {31'd0, mem_req}, 32'd0);
      i_req = 0; d_req = 0;
      tick();
      chk($sformatf("v%0d idle grant", v), {30'd0, grant}, 32'd0);
      chk($sformatf("v%0d ready cleared", v), {30'd0, i_ready, d_ready}, 32'd0);
    end

    // tie: D store first, I picked up in the following IDLE
    i_req = 1; i_addr = 32'h0000_0020; d_req = 1; d_we = 1; d_be = 4'h3;
    d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; rd_val = 32'h0000_1234;
    tick();
    chk("tie grant D", {30'd0, grant}, 32'd2);
    chk("tie mem_we", {31'd0, mem_we}, 32'd1);
    chk("tie mem_be", {28'd0, mem_be}, 32'h3);
    tick();
    chk("tie d_ready", {30'd0, i_ready, d_ready}, 32'd1);
    chk("tie d_rdata store", d_rdata, 32'd0);
    d_req = 0;
    tick();
    chk("tie idle gap", {30'd0, grant}, 32'd0);
    tick();
    chk("tie grant I", {30'd0, grant}, 32'd1);
    chk("tie I addr", mem_addr, 32'h0000_0020);
    tick();
    chk("tie i_ready", {30'd0, i_ready, d_ready}, 32'd2);
    chk("tie i_rdata", i_rdata, 32'h0000_1234);
    i_req = 0;
    tick();

    // starvation: both held high, expect D x4, I, D
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h0000_0500; i_addr = 32'h0000_0600;
    rd_val = 32'h0000_00AA;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("starve grant %0d", t), {30'd0, grant}, {30'd0, starve_exp[t]});
      tick();
      chk($sformatf("starve ready %0d", t), {30'd0, d_ready, i_ready}, {30'd0, starve_exp[t]});
      if (t == 5) begin
        i_req = 0; d_req = 0;
      end
      tick();
    end
    tick();

    // timeout: load with no ack
    ack_delay = -1; rd_val = 32'h7777_7777;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0300;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req) n++;
      else break;
    end
    chk("timeout mem_req cycles", n, 8);
    chk("timeout d_ready/err", {30'd0, d_ready, err}, 32'd3);
    chk("timeout d_rdata", d_rdata, 32'd0);
    d_req = 0;
    tick();
    chk("timeout err cleared", {30'd0, d_ready, err}, 32'd0);
    tick();

    // delayed ack with illegal input changes and withdrawal during ISSUE
    ack_delay = 5; rd_val = 32'h4242_4242;
    d_req = 1; d_we = 1; d_be = 4'h5; d_addr = 32'h0000_0400; d_wdata = 32'h1357_9BDF;
    tick();
    chk("delay mem_req", {31'd0, mem_req}, 32'd1);
    d_addr = 32'h0000_0999; d_be = 4'hF; d_wdata = 32'h0; d_req = 0;
    n = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (!mem_req) break;
      n++;
      chk("stable mem_addr", mem_addr, 32'h0000_0400);
      chk("stable mem_be", {28'd0, mem_be}, 32'h5);
      chk("stable mem_wdata", mem_wdata, 32'h1357_9BDF);
    end
    chk("delay mem_req cycles", n, 6);
    chk("delay d_ready", {30'd0, d_ready, err}, 32'd2);
    chk("delay d_rdata store", d_rdata, 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("spurious RESP grant", {30'd0, grant}, 32'd0);
    chk("spurious RESP no req", {30'd0, mem_req, d_ready}, 32'd0);
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("spurious IDLE quiet", {28'd0, grant, mem_req, d_ready}, 32'd0);
    end

    // reset while in ISSUE
    ack_delay = -1;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0800;
    tick();
    chk("rst-mid mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst-mid async grant/req", {29'd0, grant, mem_req}, 32'd0);
    chk("rst-mid async mem_addr", mem_addr, 32'd0);
    d_req = 0;
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst-mid no d_ready", {29'd0, grant, d_ready}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (instruction port, I) and the memory stage (data port, D) of the 5-stage pipeline.
- Serialises requests, holds each grant until the memory acknowledges, and returns a registered response to the owning requester.
- The core uses the `*_ready` outputs to drive pipeline stall. A starvation guard and an acknowledge timeout prevent indefinite blocking.

Parameters:
- WIDTH, 32, address and data width.
- STARVE_LIMIT, 4, consecutive D grants allowed while i_req is pending before I is forced next (1..15).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, level; held until i_ready.
- i_addr  in  WIDTH  fetch byte address.
- i_rdata  out  WIDTH  fetched word; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request, level; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  WIDTH  data byte address.
- d_wdata  in  WIDTH  store data.
- d_rdata  out  WIDTH  load data; valid while d_ready=1; 0 for stores.
- d_ready  out  1  one-cycle completion pulse for D.
- err  out  1  one-cycle pulse coincident with a ready caused by timeout.
- grant  out  2  current owner, one-hot: {D,I}; 00 when idle.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables; 4'b1111 for I and for loads.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data; valid when mem_ack=1.
- mem_ack  in  1  single-cycle memory acknowledge.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; all outputs 0; starvation counter 0; timeout counter 0.
  - An in-flight transaction is dropped silently; no ready is issued.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - Samples i_req and d_req.
  - If neither is high, stay in IDLE.
  - If one is high, grant it.
  - If both are high, grant D, unless starve_cnt == STARVE_LIMIT, in which case grant I.
  - On a grant: latch addr, we, be and wdata (I uses we=0, be=1111), set grant, and go to ISSUE.
- ISSUE:
  - mem_req=1 and mem_* are stable from the latched values.
  - On mem_ack=1: capture mem_rdata (forced to 0 for stores), drop mem_req on the next edge, go to RESP.
  - If TIMEOUT≠0 and the timeout counter reaches TIMEOUT without mem_ack: drop mem_req, capture data 0, set the error flag, go to RESP.
- RESP:
  - Pulse the owner's ready for exactly one cycle with the captured data; pulse err if flagged.
  - Clear grant and return to IDLE.
  - The requester drops or changes req on the edge at which ready is high.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high at cycle 1.
  - mem_ack at cycle k (k≥1) → ready at cycle k+1.
  - Minimum request-to-ready latency is 2 cycles.
  - Back-to-back transactions cost 3 cycles each when the memory acks at once.
- Starvation counter:
  - Increments on each D grant while i_req=1, saturating at STARVE_LIMIT.
  - Clears on any I grant, or in IDLE when i_req=0.
- Request withdrawal: deasserting req during ISSUE is a requester protocol violation. The arbiter still completes the transaction and pulses ready.
- A mem_ack outside ISSUE is ignored.
- i_ready and d_ready are never high in the same cycle. grant is never 11.
- The timeout counter clears on every entry to ISSUE. The count is inclusive: abort occurs on the TIMEOUT-th ISSUE cycle with no ack.

Test Plan:
- **Reset mid-transaction.** d_req=1 granted; assert rst=0 while in ISSUE → all outputs 0 asynchronously. After release with no requests: grant=00, and no d_ready ever pulses.
- **Single fetch, immediate ack.** i_req=1, i_addr=0x0000_0010; memory acks on the first mem_req cycle with rdata 0x0050_0513 → mem_addr=0x10, mem_be=1111, mem_we=0; i_ready pulses 2 cycles after the request with i_rdata=0x0050_0513.
- **Simultaneous requests.** i_req=d_req=1 with d_we=1, d_be=0011, d_wdata=0xDEAD_BEEF, d_addr=0x100 → D served first: mem_we=1, mem_be=0011; d_ready pulses with d_rdata=0. I is granted in the following IDLE.
- **Starvation guard.** STARVE_LIMIT=4; i_req held high; d_req re-asserted immediately after every d_ready → exactly 4 D grants, then an I grant, then D resumes.
- **Timeout.** TIMEOUT=8; d_req load with mem_ack held 0 → mem_req high for 8 cycles then drops; d_ready and err pulse together with d_rdata=0.
- **Delayed ack and stability.** mem_ack delayed 5 cycles; d_addr changed illegally during ISSUE → mem_addr, mem_be and mem_wdata hold their latched values throughout; a spurious mem_ack injected during RESP/IDLE is ignored.
